// File: rtl/gf_reduce.sv
// Iterative GF(2^WIDTH) reducer: folds a 2*WIDTH-bit carry-less product modulo POLY, one high bit per clock.
// Optional GF_REDUCE_EARLY_EXIT_EN: leave BUSY as soon as the upper half of the work register is clear.
module gf_reduce #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH:0]   POLY  = 9'h11B
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [2*WIDTH-1:0]   product_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     result_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     work;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  result_q;

    logic [PW-1:0]     poly_ext;
    logic [CW-1:0]     shamt;
    logic [PW-1:0]     work_step;
    logic              last_step;
    logic              finish;
    logic              accept;

    assign poly_ext  = PW'(POLY);
    assign shamt     = cnt - CW'(WIDTH);
    assign work_step = work[cnt] ? (work ^ (poly_ext << shamt)) : work;
    assign last_step = (cnt == CW'(WIDTH));
    assign accept    = (state == IDLE) && valid_i;

`ifdef GF_REDUCE_EARLY_EXIT_EN
    // Bits above cnt are already cleared by earlier steps, so the whole upper half stands in for work[cnt:WIDTH].
    logic upper_zero;
    assign upper_zero = ~|work[PW-1:WIDTH];
    assign finish     = last_step | upper_zero;
`else
    assign finish     = last_step;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i) state_nxt = BUSY;
            BUSY:    if (finish)  state_nxt = DONE;
            DONE:    if (ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            work     <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (accept) begin
            work <= product_i;
            cnt  <= CW'(PW - 1);
        end else if (state == BUSY) begin
`ifdef GF_REDUCE_EARLY_EXIT_EN
            if (upper_zero) begin
                result_q <= work[WIDTH-1:0];
            end else begin
                work <= work_step;
                cnt  <= cnt - 1'b1;
                if (last_step) result_q <= work_step[WIDTH-1:0];
            end
`else
            work <= work_step;
            cnt  <= cnt - 1'b1;
            if (last_step) result_q <= work_step[WIDTH-1:0];
`endif
        end
    end

    assign ready_o  = (state == IDLE);
    assign valid_o  = (state == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_gf_reduce.sv
// Directed bench for gf_reduce (AES field), hand-computed expected residues and latencies.
module tb_gf_reduce;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] product_i;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  result_o;

    int n_chk  = 0;
    int n_pass = 0;

    gf_reduce #(.WIDTH(8), .POLY(9'h11B)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .product_i(product_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Issue one product, wait for valid_o, check result and (optionally) latency counted
    // in clocks including the accepting edge. Leaves the block in DONE when hold=1.
    task automatic run_op(input string tag, input logic [15:0] prod, input logic [7:0] exp,
                          input int exp_lat, input bit hold);
        int lat;
        chk({tag, ".ready"}, ready_o, 1'b1);
        valid_i   = 1'b1;
        product_i = prod;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
        end
        chk({tag, ".valid"}, valid_o, 1'b1);
        chk({tag, ".result"}, result_o, exp);
        if (exp_lat > 0) chk({tag, ".latency"}, lat, exp_lat);
        if (!hold) begin
            ready_i = 1'b1;
            @(posedge clk_i); #1;
            ready_i = 1'b0;
            chk({tag, ".valid_drop"}, valid_o, 1'b0);
            chk({tag, ".result_kept"}, result_o, exp);
        end
    endtask

    initial begin
        int lat_full, lat_a5;
        bit stable;
        bit spurious;
`ifdef GF_REDUCE_EARLY_EXIT_EN
        lat_full = 0;
        lat_a5   = 2;
`else
        lat_full = 9;
        lat_a5   = 9;
`endif
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; product_i = '0;
        #1;
        chk("rst.ready", ready_o, 1'b1);
        chk("rst.valid", valid_o, 1'b0);
        chk("rst.result", result_o, 8'h00);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_op("v57x83", 16'h2B79, 8'hC1, lat_full, 0);
        run_op("v57x13", 16'h0589, 8'hFE, 0, 0);
        run_op("x8",     16'h0100, 8'h1B, 0, 0);
        run_op("x15",    16'h8000, 8'h2F, 0, 0);
        run_op("x14",    16'h4000, 8'h9A, 0, 0);
        run_op("zero",   16'h0000, 8'h00, 0, 0);
        run_op("lowA5",  16'h00A5, 8'hA5, lat_a5, 0);

        // Backpressure: hold DONE for 20 cycles with valid_i pulses that must be ignored.
        run_op("bp", 16'h2B79, 8'hC1, 0, 1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            valid_i   = i[0];
            product_i = 16'h8000;
            @(posedge clk_i); #1;
            if (!valid_o || ready_o || result_o !== 8'hC1) stable = 1'b0;
        end
        valid_i = 1'b0;
        chk("bp.stable", stable, 1'b1);
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        chk("bp.release", valid_o, 1'b0);
        chk("bp.kept", result_o, 8'hC1);

        // Reset mid-BUSY discards the product with no valid_o pulse.
        valid_i = 1'b1; product_i = 16'h0589;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk("midrst.ready", ready_o, 1'b1);
        chk("midrst.valid", valid_o, 1'b0);
        chk("midrst.result", result_o, 8'h00);
        @(posedge clk_i); #1 rst_i = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            if (valid_o) spurious = 1'b1;
        end
        chk("midrst.no_valid", spurious, 1'b0);
        run_op("post_rst", 16'h0589, 8'hFE, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gf_reduce.md
Name: gf_reduce

Overview:
- Iterative polynomial reducer. Takes the unreduced 2*WIDTH-bit carry-less product from the GF multiplier and reduces it modulo the field polynomial POLY to a WIDTH-bit field element.
- Processes one high-order bit per clock, so the datapath stays small.
- Has a valid/ready handshake on both sides. Sits directly downstream of the multiplier in the MixColumns / InvMixColumns path.

Parameters:
- WIDTH, 8, field element width in bits.
- POLY, 9'h11B, irreducible polynomial, WIDTH+1 bits, MSB must be 1 (AES x^8+x^4+x^3+x+1).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  input product valid.
- ready_o  output  1  block can accept a product.
- product_i  input  2*WIDTH  unreduced carry-less product.
- valid_o  output  1  result_o holds a reduced result.
- ready_i  input  1  downstream accepts the result.
- result_o  output  WIDTH  reduced product, product_i mod POLY.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - Work register and bit counter cleared.
  - valid_o = 0, ready_o = 1, result_o = 0.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - ready_o = 1.
  - On valid_i && ready_o: load work register with product_i, set counter = 2*WIDTH-1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - ready_o = 0; valid_i is ignored.
  - Each cycle: if work[cnt] = 1, then work ^= POLY << (cnt-WIDTH). Then cnt decrements.
  - When the step just performed used cnt == WIDTH: result_o <= reduced work[WIDTH-1:0], go to DONE.
  - Exactly WIDTH BUSY cycles (bits 2*WIDTH-1 down to WIDTH). Bit 2*WIDTH-1 is processed even though a WIDTH x WIDTH product never sets it.
- DONE:
  - valid_o = 1; result_o is stable and held.
  - On ready_i: go to IDLE, valid_o drops next cycle.
  - With ready_i low, hold indefinitely (backpressure). result_o must not change while valid_o = 1.
- Latency (feature off): valid_o rises WIDTH+1 clocks after the accepting edge, i.e. 9 clocks for WIDTH=8.
- Throughput: one product per WIDTH+2 cycles minimum. No overlap; ready_o is 0 in BUSY and DONE.
- result_o:
  - Updates only on entry to DONE.
  - Retains its last value after the handshake, until the next DONE entry.
- Reset mid-operation: in-flight product is discarded and the block returns to IDLE with reset values. No spurious valid_o pulse.
- Arithmetic is XOR only. No carries; widths as stated; no truncation beyond the final WIDTH bits.

Optional Feature:
- Macro: GF_REDUCE_EARLY_EXIT_EN.
- Defined:
  - In BUSY, if work[cnt:WIDTH] == 0 at the start of a cycle, that edge captures result_o <= work[WIDTH-1:0] and goes to DONE.
  - Latency becomes variable: minimum 2 clocks from accept (upper half already zero), maximum WIDTH+1.
  - Results are identical to the feature-off build.
- Undefined: fixed WIDTH-cycle BUSY phase for all inputs; no early-exit comparator is synthesized.

Test Plan:
- product_i=16'h2B79 (0x57·0x83) -> result_o=8'hC1; valid_o exactly 9 clocks after accept (feature off).
- product_i=16'h0589 (0x57·0x13) -> result_o=8'hFE.
- product_i=16'h0100 -> 8'h1B.
- product_i=16'h8000 -> 8'h2F.
- product_i=16'h00A5:
  - -> 8'hA5 in both builds.
  - Feature on: valid_o 2 clocks after accept.
  - Feature off: 9 clocks.
- Backpressure and reset:
  - Hold ready_i=0 for 20 cycles in DONE -> valid_o and result_o stable, ready_o=0; valid_i pulses ignored.
  - Assert rst_i during BUSY -> outputs return to reset values immediately, no valid_o.
  - After reset, the next product reduces correctly.
